// File: rtl/iter_mult_display.sv
// Iterative shift-add multiplier with LCD slot readout.
//
// Two operands are written from the touchscreen (input_valid/input_sel/input_value).
// A rising edge on the sw_begin level switch starts a radix-2 multiply that takes
// WIDTH cycles in RUN plus one FIN cycle. mult_end pulses in the cycle the registered
// product becomes valid. Operands and product are shown on LCD slots starting at
// DISP_BASE; values are sign- or zero-extended according to the last finished op.
//
// Parameters:
//   WIDTH      operand width, even, 8..32
//   DISP_BASE  first display slot number, 1..40
// Optional build macro:
//   MULT_CYCLE_CNT_EN  adds a saturating cycle counter shown at slot DISP_BASE+4
//
// Ports:
//   clk             clock
//   reset           asynchronous active-high reset
//   input_valid     one-cycle strobe qualifying input_value
//   input_value     operand value, bits [WIDTH-1:0] used
//   input_sel       0 writes op1, 1 writes op2
//   sw_begin        level switch, rising edge requests a multiply
//   signed_mode     1 selects two's-complement operands, sampled at start
//   display_number  slot requested by the LCD
//   display_valid   slot belongs to this block (registered)
//   display_name    5-character ASCII label (registered)
//   display_value   slot value (registered)
//   mult_busy       high in RUN and FIN
//   mult_end        one-cycle pulse when product is captured
//   product         registered 2*WIDTH-bit result
module iter_mult_display #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DISP_BASE = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               input_valid,
  input  logic [31:0]        input_value,
  input  logic               input_sel,
  input  logic               sw_begin,
  input  logic               signed_mode,
  input  logic [5:0]         display_number,
  output logic               display_valid,
  output logic [39:0]        display_name,
  output logic [31:0]        display_value,
  output logic               mult_busy,
  output logic               mult_end,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  localparam logic [5:0] SlotOp1 = 6'(DISP_BASE);
  localparam logic [5:0] SlotOp2 = 6'(DISP_BASE + 1);
  localparam logic [5:0] SlotPrH = 6'(DISP_BASE + 2);
  localparam logic [5:0] SlotPrL = 6'(DISP_BASE + 3);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  // sw_begin is registered once before edge detection; the history register
  // resets to 1 so a switch held through reset cannot fire a start.
  logic sw_q, sw_prev_q;
  logic start;

  logic [WIDTH-1:0] op1_q, op2_q;
  logic [WIDTH-1:0] op1_abs, op2_abs;

  // Working registers, loaded only at start.
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_next;
  logic [CntW-1:0]  bit_cnt_q;
  logic             neg_q;
  logic             sgn_work_q;

  logic             sgn_last_q;
  logic [PW-1:0]    product_q;
  logic             mult_end_q;

  logic [31:0] op1_ext, op2_ext;
  logic [63:0] prod_ext;

  logic        disp_valid_d, disp_valid_q;
  logic [39:0] disp_name_d, disp_name_q;
  logic [31:0] disp_value_d, disp_value_q;

  assign start = sw_q & ~sw_prev_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (bit_cnt_q == LastBit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mult_busy = (state_q != StIdle);
  assign mult_end  = mult_end_q;
  assign product   = product_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Magnitudes are taken as WIDTH-bit unsigned, so the most-negative value maps
  // onto itself and is still the correct magnitude.
  always_comb begin
    op1_abs = (signed_mode && op1_q[WIDTH-1]) ? (~op1_q) + WIDTH'(1) : op1_q;
    op2_abs = (signed_mode && op2_q[WIDTH-1]) ? (~op2_q) + WIDTH'(1) : op2_q;
    acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q       <= 1'b1;
      sw_prev_q  <= 1'b1;
      op1_q      <= '0;
      op2_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      neg_q      <= 1'b0;
      sgn_work_q <= 1'b0;
      sgn_last_q <= 1'b0;
      product_q  <= '0;
      mult_end_q <= 1'b0;
    end else begin
      sw_q      <= sw_begin;
      sw_prev_q <= sw_q;

      // Operand registers stay writable in every state; the multiply in flight
      // works from its own snapshot.
      if (input_valid) begin
        if (input_sel) begin
          op2_q <= input_value[WIDTH-1:0];
        end else begin
          op1_q <= input_value[WIDTH-1:0];
        end
      end

      mult_end_q <= (state_q == StFin);

      case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q    <= PW'(op1_abs);
            mplier_q   <= op2_abs;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            neg_q      <= signed_mode & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
            sgn_work_q <= signed_mode;
          end
        end
        StRun: begin
          acc_q     <= acc_next;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          bit_cnt_q <= bit_cnt_q + CntW'(1);
        end
        StFin: begin
          product_q  <= neg_q ? (~acc_q) + PW'(1) : acc_q;
          sgn_last_q <= sgn_work_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_CYCLE_CNT_EN
  // ---------------------------------------------------------------------------
  // Cycle counter: cleared at start, counts RUN and FIN cycles, saturates.
  // ---------------------------------------------------------------------------
  localparam logic [5:0] SlotCyc = 6'(DISP_BASE + 4);

  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      cyc_cnt_q <= '0;
    end else if ((state_q != StIdle) && (cyc_cnt_q != '1)) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Display slots
  // ---------------------------------------------------------------------------
  assign op1_ext  = sgn_last_q ? 32'($signed(op1_q)) : 32'(op1_q);
  assign op2_ext  = sgn_last_q ? 32'($signed(op2_q)) : 32'(op2_q);
  assign prod_ext = sgn_last_q ? 64'($signed(product_q)) : 64'(product_q);

  always_comb begin
    disp_valid_d = 1'b0;
    disp_name_d  = '0;
    disp_value_d = '0;
    if (display_number == SlotOp1) begin
      disp_valid_d = 1'b1;
      disp_name_d  = "M_OP1";
      disp_value_d = op1_ext;
    end else if (display_number == SlotOp2) begin
      disp_valid_d = 1'b1;
      disp_name_d  = "M_OP2";
      disp_value_d = op2_ext;
    end else if (display_number == SlotPrH) begin
      disp_valid_d = 1'b1;
      disp_name_d  = "PRO_H";
      disp_value_d = prod_ext[63:32];
    end else if (display_number == SlotPrL) begin
      disp_valid_d = 1'b1;
      disp_name_d  = "PRO_L";
      disp_value_d = prod_ext[31:0];
`ifdef MULT_CYCLE_CNT_EN
    end else if (display_number == SlotCyc) begin
      disp_valid_d = 1'b1;
      disp_name_d  = "CYCLE";
      disp_value_d = cyc_cnt_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      disp_name_q  <= '0;
      disp_value_q <= '0;
    end else begin
      disp_valid_q <= disp_valid_d;
      disp_name_q  <= disp_name_d;
      disp_value_q <= disp_value_d;
    end
  end

  assign display_valid = disp_valid_q;
  assign display_name  = disp_name_q;
  assign display_value = disp_value_q;

endmodule

// File: tb/tb_iter_mult_display.sv
module tb_iter_mult_display;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance, DISP_BASE 5
  logic        iv, isel, sw, sm;
  logic [31:0] ival;
  logic [5:0]  dn;
  logic        dv, busy, mend;
  logic [39:0] dname;
  logic [31:0] dval;
  logic [63:0] prod;

  // 8-bit instance, DISP_BASE 1
  logic        iv8, isel8, sw8, sm8;
  logic [31:0] ival8;
  logic [5:0]  dn8;
  logic        dv8, busy8, mend8;
  logic [39:0] dname8;
  logic [31:0] dval8;
  logic [15:0] prod8;

  iter_mult_display #(.WIDTH(32), .DISP_BASE(5)) dut (
    .clk(clk), .reset(reset), .input_valid(iv), .input_value(ival), .input_sel(isel),
    .sw_begin(sw), .signed_mode(sm), .display_number(dn), .display_valid(dv),
    .display_name(dname), .display_value(dval), .mult_busy(busy), .mult_end(mend),
    .product(prod)
  );

  iter_mult_display #(.WIDTH(8), .DISP_BASE(1)) dut8 (
    .clk(clk), .reset(reset), .input_valid(iv8), .input_value(ival8), .input_sel(isel8),
    .sw_begin(sw8), .signed_mode(sm8), .display_number(dn8), .display_valid(dv8),
    .display_name(dname8), .display_value(dval8), .mult_busy(busy8), .mult_end(mend8),
    .product(prod8)
  );

  logic        use8 = 1'b0;
  logic        s_end, s_dv;
  logic [39:0] s_name;
  logic [31:0] s_val;
  logic [63:0] s_prod;

  always_comb begin
    s_end  = use8 ? mend8 : mend;
    s_dv   = use8 ? dv8 : dv;
    s_name = use8 ? dname8 : dname;
    s_val  = use8 ? dval8 : dval;
    s_prod = use8 ? {48'b0, prod8} : prod;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_sw(input logic v);
    if (use8) sw8 = v; else sw = v;
  endtask

  task automatic write_op(input logic [31:0] v, input logic sel);
    if (use8) begin iv8 = 1'b1; ival8 = v; isel8 = sel; end
    else begin iv = 1'b1; ival = v; isel = sel; end
    @(negedge clk);
    iv = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic check_slot(input string tag, input logic [5:0] num, input logic ev,
                            input logic [39:0] en, input logic [31:0] eval);
    if (use8) dn8 = num; else dn = num;
    @(negedge clk);
    check({tag, " valid"}, {63'b0, s_dv}, {63'b0, ev});
    check({tag, " name"}, {24'b0, s_name}, {24'b0, en});
    check({tag, " value"}, {32'b0, s_val}, {32'b0, eval});
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] expv);
    int          w;
    logic        got;
    logic [63:0] e;
    logic [5:0]  base;
    w    = use8 ? 8 : 32;
    base = use8 ? 6'd1 : 6'd5;
    write_op(a, 1'b0);
    write_op(b, 1'b1);
    if (use8) sm8 = sgn; else sm = sgn;
    exp_q.push_back(expv);
    drive_sw(1'b1);
    got = 1'b0;
    for (int n = 0; n < w + 20 && !got; n++) begin
      @(negedge clk);
      if (s_end) begin
        got = 1'b1;
        check({tag, " latency"}, 64'(n), 64'(w + 2));
      end
    end
    check({tag, " end seen"}, {63'b0, got}, 64'd1);
    e = exp_q.pop_front();
    if (got) check({tag, " product"}, s_prod, use8 ? {48'b0, e[15:0]} : e);
    drive_sw(1'b0);
    check_slot({tag, " PRO_H"}, base + 6'd2, 1'b1, "PRO_H", e[63:32]);
    check_slot({tag, " PRO_L"}, base + 6'd3, 1'b1, "PRO_L", e[31:0]);
  endtask

  int          ends, first_n, busy_hits;
  logic [63:0] cap, e;

  initial begin
    reset = 1'b1;
    iv = 1'b0; isel = 1'b0; ival = '0; sw = 1'b1; sm = 1'b0; dn = '0;
    iv8 = 1'b0; isel8 = 1'b0; ival8 = '0; sw8 = 1'b1; sm8 = 1'b0; dn8 = '0;
    repeat (3) @(negedge clk);

    // Reset state, switch held high through reset
    check("rst busy", {63'b0, busy}, 64'd0);
    check("rst end", {63'b0, mend}, 64'd0);
    check("rst product", prod, 64'd0);
    check("rst disp valid", {63'b0, dv}, 64'd0);
    check("rst disp name", {24'b0, dname}, 64'd0);
    check("rst disp value", {32'b0, dval}, 64'd0);
    reset = 1'b0;
    busy_hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || busy8) busy_hits++;
    end
    check("held switch no start", 64'(busy_hits), 64'd0);
    sw = 1'b0;
    sw8 = 1'b0;
    @(negedge clk);

    // Directed multiplies on the 32-bit instance
    run_mult("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    run_mult("uFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_mult("sm2x3", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mult("sminxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_mult("sminx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    check_slot("op1 slot", 6'd5, 1'b1, "M_OP1", 32'h8000_0000);
    check_slot("op2 slot", 6'd6, 1'b1, "M_OP2", 32'h0000_0001);

    // Restart and operand write during RUN: one result from the snapshot
    write_op(32'd7, 1'b0);
    write_op(32'd9, 1'b1);
    sm = 1'b0;
    exp_q.push_back(64'd63);
    sw = 1'b1;
    ends = 0;
    first_n = -1;
    cap = '0;
    for (int n = 0; n < 90; n++) begin
      @(negedge clk);
      if (mend) begin
        ends++;
        if (ends == 1) begin first_n = n; cap = prod; end
      end
      if (n == 3) sw = 1'b0;
      if (n == 5) sw = 1'b1;
      if (n == 7) begin iv = 1'b1; isel = 1'b0; ival = 32'd2; end
      else iv = 1'b0;
    end
    sw = 1'b0;
    e = exp_q.pop_front();
    check("restart end count", 64'(ends), 64'd1);
    check("restart latency", 64'(first_n), 64'd34);
    check("restart product", cap, e);
    check_slot("restart op1", 6'd5, 1'b1, "M_OP1", 32'd2);

    // Reset in the middle of RUN
    write_op(32'd11, 1'b0);
    write_op(32'd13, 1'b1);
    exp_q.push_back(64'd143);
    sw = 1'b1;
    ends = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mend) ends++;
    end
    reset = 1'b1;
    #1;
    check("midrun rst busy", {63'b0, busy}, 64'd0);
    check("midrun rst end", {63'b0, mend}, 64'd0);
    check("midrun rst product", prod, 64'd0);
    // The interrupted operation never completes; drop its expectation.
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    busy_hits = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (mend) ends++;
      if (busy) busy_hits++;
    end
    check("midrun no end", 64'(ends), 64'd0);
    check("midrun stays idle", 64'(busy_hits), 64'd0);
    sw = 1'b0;
    @(negedge clk);
    run_mult("after rst", 32'd11, 32'd13, 1'b0, 64'd143);

    // Unowned slots
    check_slot("slot 0", 6'd0, 1'b0, 40'd0, 32'd0);
    check_slot("slot 10", 6'd10, 1'b0, 40'd0, 32'd0);
`ifdef MULT_CYCLE_CNT_EN
    check_slot("cycle32", 6'd9, 1'b1, "CYCLE", 32'd33);
`else
    check_slot("slot 9", 6'd9, 1'b0, 40'd0, 32'd0);
`endif

    // 8-bit instance: zero then sign extension on the display
    use8 = 1'b1;
    run_mult("w8 unsigned", 32'h80, 32'h7F, 1'b0, 64'h0000_0000_0000_3F80);
    check_slot("w8 op1 zext", 6'd1, 1'b1, "M_OP1", 32'h0000_0080);
    run_mult("w8 signed", 32'h80, 32'h7F, 1'b1, 64'hFFFF_FFFF_FFFF_C080);
    check_slot("w8 op1 sext", 6'd1, 1'b1, "M_OP1", 32'hFFFF_FF80);
    check_slot("w8 op2", 6'd2, 1'b1, "M_OP2", 32'h0000_007F);
`ifdef MULT_CYCLE_CNT_EN
    check_slot("w8 cycle", 6'd5, 1'b1, "CYCLE", 32'd9);
`else
    check_slot("w8 slot 5", 6'd5, 1'b0, 40'd0, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
